// File: rtl/scope_eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scope_eth_pkg
// Purpose  : Shared constants and FSM state encoding for the scope Ethernet
//            command path.
// Contents : c_byte_w            - width of one payload byte
//            c_udp_max_payload   - largest UDP payload that fits one frame
//            c_st_*              - command transmitter state encoding
// Revision : 1.0 - initial release
// ============================================================================
package scope_eth_pkg;

    localparam int unsigned c_byte_w          = 8;
    localparam int unsigned c_udp_max_payload = 1472;

    localparam int unsigned c_state_w = 2;
    localparam logic [c_state_w-1:0] c_st_idle     = 2'd0;
    localparam logic [c_state_w-1:0] c_st_wait_rdy = 2'd1;
    localparam logic [c_state_w-1:0] c_st_send     = 2'd2;
    localparam logic [c_state_w-1:0] c_st_gap      = 2'd3;

endpackage
`default_nettype wire

// File: rtl/udp_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : udp_byte_serializer
// Purpose  : Loads a P_BYTES-wide word and presents it one byte at a time,
//            most significant byte first, with a flag on the final byte.
// Ports    : i_clk, i_rst  - clock, synchronous active-high reset
//            i_load        - capture i_word and restart at byte 0
//            i_shift       - advance to the next byte
//            i_word        - word to serialise
//            o_byte        - current byte (combinational from the register)
//            o_last        - current byte is index P_BYTES-1
// Revision : 1.0 - initial release
// ============================================================================
module udp_byte_serializer
    import scope_eth_pkg::*;
#(
    parameter int unsigned P_BYTES = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_load,
    input  logic                         i_shift,
    input  logic [c_byte_w*P_BYTES-1:0]  i_word,
    output logic [c_byte_w-1:0]          o_byte,
    output logic                         o_last
);

    localparam int unsigned c_word_w = c_byte_w * P_BYTES;
    // A single-byte frame still needs a 1-bit index register.
    localparam int unsigned c_idx_w  = (P_BYTES > 1) ? $clog2(P_BYTES) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(P_BYTES - 1);

    logic [c_word_w-1:0] r_sreg;
    logic [c_idx_w-1:0]  r_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sreg <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_sreg <= i_word;
            r_idx  <= '0;
        end else if (i_shift) begin
            // The index may wrap past the last byte on the final shift; the
            // next frame always reloads before it is used again.
            r_sreg <= r_sreg << c_byte_w;
            r_idx  <= r_idx + c_idx_w'(1);
        end
    end

    assign o_byte = r_sreg[c_word_w-1 -: c_byte_w];
    assign o_last = (r_idx == c_last_idx);

endmodule
`default_nettype wire

// File: rtl/scope_udp_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module   : scope_udp_cmd_tx
// Purpose  : Latches a command word and sends it as one or more UDP frames,
//            MSB byte first, on the UDP stack user send interface. Supports
//            repeat bursts with an inter-frame gap and an optional rolling
//            sequence number in the final byte of every frame.
// Ports    : i_clk, i_rst               - UDP clock, sync active-high reset
//            i_cmd_data/valid, o_cmd_ready - command request handshake
//            i_repeat, i_gap, i_seq_en  - burst controls, latched at accept
//            o_send_len/data/last/valid, i_send_ready - UDP stack interface
//            o_busy, o_done, o_seq      - status
// Revision : 1.0 - initial release
// ============================================================================
module scope_udp_cmd_tx
    import scope_eth_pkg::*;
#(
    parameter int unsigned P_BYTES = 8,
    parameter int unsigned P_CNT_W = 8,
    parameter int unsigned P_GAP_W = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [c_byte_w*P_BYTES-1:0]  i_cmd_data,
    input  logic                         i_cmd_valid,
    output logic                         o_cmd_ready,
    input  logic [P_CNT_W-1:0]           i_repeat,
    input  logic [P_GAP_W-1:0]           i_gap,
    input  logic                         i_seq_en,
    output logic [15:0]                  o_send_len,
    output logic [7:0]                   o_send_data,
    output logic                         o_send_last,
    output logic                         o_send_valid,
    input  logic                         i_send_ready,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [7:0]                   o_seq
);

    localparam logic [15:0] c_frame_len = 16'(P_BYTES);

    logic [c_state_w-1:0]          r_state;
    logic [c_state_w-1:0]          w_state_next;

    logic [c_byte_w*P_BYTES-1:0]   r_cmd_word;
    logic [P_GAP_W-1:0]            r_gap;
    logic [P_GAP_W-1:0]            r_gap_cnt;
    logic                          r_seq_en;
    logic [P_CNT_W-1:0]            r_remain;
    logic [7:0]                    r_seq;

    logic [15:0]                   r_send_len;
    logic [7:0]                    r_send_data;
    logic                          r_send_last;
    logic                          r_send_valid;
    logic                          r_done_pend;
    logic                          r_done;

    logic                          w_accept;
    logic                          w_load;
    logic                          w_shift;
    logic                          w_frame_end;
    logic                          w_last_frame;
    logic [7:0]                    w_ser_byte;
    logic                          w_ser_last;

    assign w_last_frame = (r_remain == P_CNT_W'(1));

    udp_byte_serializer #(
        .P_BYTES (P_BYTES)
    ) u_ser (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_word  (r_cmd_word),
        .o_byte  (w_ser_byte),
        .o_last  (w_ser_last)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes. SEND runs one cycle ahead of the
    // registered outputs, so leaving SEND coincides with the edge that
    // registers the last byte.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (i_cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = c_st_wait_rdy;
                end
            end
            c_st_wait_rdy: begin
                if (i_send_ready) begin
                    w_load       = 1'b1;
                    w_state_next = c_st_send;
                end
            end
            c_st_send: begin
                w_shift = 1'b1;
                if (w_ser_last) begin
                    w_frame_end = 1'b1;
                    if (w_last_frame) begin
                        w_state_next = c_st_idle;
                    end else if (r_gap == '0) begin
                        w_state_next = c_st_wait_rdy;
                    end else begin
                        w_state_next = c_st_gap;
                    end
                end
            end
            c_st_gap: begin
                if (r_gap_cnt <= P_GAP_W'(1)) begin
                    w_state_next = c_st_wait_rdy;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latched command fields, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmd_word   <= '0;
            r_gap        <= '0;
            r_gap_cnt    <= '0;
            r_seq_en     <= 1'b0;
            r_remain     <= '0;
            r_seq        <= '0;
            r_send_len   <= '0;
            r_send_data  <= '0;
            r_send_last  <= 1'b0;
            r_send_valid <= 1'b0;
            r_done_pend  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd_word <= i_cmd_data;
                r_gap      <= i_gap;
                r_seq_en   <= i_seq_en;
                r_remain   <= (i_repeat == '0) ? P_CNT_W'(1) : i_repeat;
            end else if (w_frame_end) begin
                r_remain <= r_remain - P_CNT_W'(1);
            end

            if (w_frame_end) begin
                r_seq     <= r_seq + 8'd1;
                r_gap_cnt <= r_gap;
            end else if (r_state == c_st_gap) begin
                r_gap_cnt <= r_gap_cnt - P_GAP_W'(1);
            end

            r_send_valid <= w_shift;
            r_send_last  <= w_shift & w_ser_last;
            r_send_len   <= w_shift ? c_frame_len : 16'd0;
            if (w_shift) begin
                r_send_data <= (w_ser_last && r_seq_en) ? r_seq : w_ser_byte;
            end else begin
                r_send_data <= 8'h00;
            end

            // The last byte becomes visible one cycle after the FSM leaves
            // SEND, so done is delayed once more to trail it.
            r_done_pend <= w_frame_end & w_last_frame;
            r_done      <= r_done_pend;
        end
    end

    // Ready drops combinationally with reset so a command presented during
    // reset is never seen as accepted.
    assign o_cmd_ready  = (r_state == c_st_idle) && !i_rst;
    assign o_busy       = (r_state != c_st_idle);
    assign o_send_len   = r_send_len;
    assign o_send_data  = r_send_data;
    assign o_send_last  = r_send_last;
    assign o_send_valid = r_send_valid;
    assign o_done       = r_done;
    assign o_seq        = r_seq;

endmodule
`default_nettype wire

// File: doc/scope_udp_cmd_tx.md
# scope_udp_cmd_tx

Parametrised command-frame transmitter for the scope-to-PC Ethernet path. Latches a P_BYTES-wide command word and serialises it MSB-byte-first onto the UDP stack user send interface (len/data/last/valid, gated by ready). It sits between scope control logic and the UDP stack in the 125 MHz UDP clock domain. Over a fixed hand-written 8-byte send it adds:
- configurable frame length;
- repeat bursts with a programmable inter-frame gap;
- an optional rolling sequence number in the final byte.

## Interface
Parameters:
- P_BYTES, 8, frame payload length in bytes; legal range 1..1472.
- P_CNT_W, 8, width of the repeat count.
- P_GAP_W, 8, width of the inter-frame gap count.

Ports:
- i_clk  in  1  UDP stack clock; one clock domain only.
- i_rst  in  1  synchronous, active-high reset.
- i_cmd_data  in  8*P_BYTES  command payload; byte 0 = bits [8*P_BYTES-1 -: 8].
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  high only in IDLE.
- i_repeat  in  P_CNT_W  frames to send; 0 is treated as 1.
- i_gap  in  P_GAP_W  idle cycles between frames of a burst.
- i_seq_en  in  1  replace the last payload byte with the sequence counter.
- o_send_len  out  16  frame length to stack; equals P_BYTES while valid, else 0.
- o_send_data  out  8  payload byte.
- o_send_last  out  1  final byte of frame.
- o_send_valid  out  1  byte valid.
- i_send_ready  in  1  stack can accept a new frame.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse after the last byte of the last frame of a burst.
- o_seq  out  8  current sequence counter.

## Operation
- States:
  - IDLE
  - WAIT_RDY
  - SEND
  - GAP
- IDLE: o_cmd_ready=1. On i_cmd_valid:
  - latch i_cmd_data, i_gap and i_seq_en;
  - set remaining = max(i_repeat,1);
  - go to WAIT_RDY.
- WAIT_RDY: on i_send_ready=1:
  - load the shift register from the latched word;
  - byte index = 0;
  - go to SEND.
- SEND:
  - One byte per cycle, no bubbles; i_send_ready is not re-checked mid-frame.
  - o_send_last=1 on byte index P_BYTES-1.
  - If i_seq_en is latched, the byte at index P_BYTES-1 is o_seq instead of the payload byte.
- After the last byte:
  - seq increments (mod 256) and remaining decrements;
  - if remaining=0: pulse o_done and go to IDLE;
  - else if gap=0: go to WAIT_RDY;
  - else go to GAP.
- GAP: count down gap cycles, then go to WAIT_RDY.
- P_BYTES=1: a single cycle carries both valid and last. With i_seq_en latched, that byte is o_seq.
- Sequence counter:
  - reset clears it to 0;
  - it wraps 255→0;
  - it persists across bursts.
- Inputs changing during a burst have no effect; all fields are latched at accept.

## Timing
- Reset value of every output is 0, except o_cmd_ready, which is 1 in the first cycle after reset release.
- While i_rst is high, o_cmd_ready=0.
- All send outputs are registered.
- Latency:
  - accept at edge T;
  - WAIT_RDY samples i_send_ready at edge T+1;
  - first valid byte is driven after edge T+2 when ready was already high.
- A frame occupies exactly P_BYTES consecutive valid cycles.
- Between frames of a burst: gap + 1 cycles of valid=0 (the WAIT_RDY cycle), plus any extra cycles waiting for ready.
- o_done is asserted in the cycle after the last-byte cycle; o_busy is low in that same cycle.
- Reset mid-frame: valid, last, len and data go to 0 at the next edge with no last emitted. The truncated frame is accepted behaviour. Sequence counter and state are cleared.
- Simultaneous i_cmd_valid and reset: reset wins and the command is dropped.

## Structure
- Shared package scope_eth_pkg holds:
  - the state encoding (IDLE/WAIT_RDY/SEND/GAP);
  - the byte width constant 8;
  - the maximum UDP payload constant 1472.
- One sub-module: udp_byte_serializer.
  - Role: P_BYTES-wide load and shift register with byte counter and last flag.
  - Driven by: the FSM in scope_udp_cmd_tx.

## Test plan
- Default P_BYTES=8; i_cmd_data=64_00_01_00_00_00_01_00h, repeat=1, seq off, ready=1 → bytes 0x64,0,1,0,0,0,1,0; last on the 8th; len=8 throughout; o_done 1 cycle later.
- repeat=3, gap=4, seq on → 3 frames with final bytes 0,1,2; exactly 5 invalid cycles between frames; o_seq=3 at end.
- Hold i_send_ready=0 for 20 cycles after accept → no valid until ready rises; first byte 2 cycles after ready seen high.
- Sequence wrap: 257 single frames with seq on → 256th frame last byte 0xFF, 257th 0x00.
- Assert i_rst at byte index 3 of a frame → valid=0 next cycle, no last; o_seq=0; o_cmd_ready=1 one cycle after reset release.
- P_BYTES=1 instance, repeat=0 → exactly one frame with valid and last in the same cycle; repeat=0 behaves as 1.
